// File: rtl/counter_enable_ctrl_if.sv
// Purpose : groups the button/step requests and the enable/status outputs of counter_enable_ctrl.
// Latency : n/a (signal bundle only).
// Backpressure: none; every signal is a level or a 1-cycle pulse, with no handshake.
// Ports (via modports):
//   btn_in      raw asynchronous push-button level, 1 = pressed   (master -> slave)
//   single_step synchronous 1-cycle request for one enable strobe (master -> slave)
//   enable      registered 1-cycle enable strobe to the counter   (slave -> master)
//   running     registered, 1 while the controller is in RUN      (slave -> master)
//   btn_evt     registered 1-cycle pulse per debounced press      (slave -> master)
interface counter_enable_ctrl_if;
   logic btn_in;
   logic single_step;
   logic enable;
   logic running;
   logic btn_evt;

   modport master (
      output btn_in,
      output single_step,
      input  enable,
      input  running,
      input  btn_evt
   );

   modport slave (
      input  btn_in,
      input  single_step,
      output enable,
      output running,
      output btn_evt
   );
endinterface

// File: rtl/counter_enable_ctrl.sv
// Purpose : run/stop + single-step controller producing the counter enable strobe from a debounced button.
// Latency : press -> btn_evt after DEBOUNCE+3 edges, btn_evt -> running 1 edge, step request -> enable 2 edges.
// Backpressure: none; requests arriving while they cannot be honoured (step in RUN/STEP, press in STEP) are dropped.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of counter_enable_ctrl_if (btn_in, single_step in; enable, running, btn_evt out)
module counter_enable_ctrl #(
   parameter int DEBOUNCE = 4,
   parameter int PRESCALE = 10,
   parameter int CNT_W    = 8
) (
   input logic                   clk,
   input logic                   reset,
   counter_enable_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] PS_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             r_s1;
   logic             r_s2;
   logic             r_db;
   logic             r_db_q;
   logic [CNT_W-1:0] r_dcnt;
   logic             r_btn_evt;

   state_t           r_state;
   logic [CNT_W-1:0] r_pcnt;
   logic             r_enable;
   logic             r_running;

   // Synchroniser, debounce and press detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_db      <= 1'b0;
         r_db_q    <= 1'b0;
         r_dcnt    <= '0;
         r_btn_evt <= 1'b0;
      end else begin
         r_s1   <= bus.btn_in;
         r_s2   <= r_s1;
         r_db_q <= r_db;
         // Pulse is taken from the registered rise of the accepted level,
         // so it lands one edge after the level itself is accepted.
         r_btn_evt <= r_db & ~r_db_q;
         if (r_s2 != r_db) begin
            // Accept only after DEBOUNCE consecutive mismatching samples.
            if (r_dcnt == DB_LAST) begin
               r_db   <= r_s2;
               r_dcnt <= '0;
            end else begin
               r_dcnt <= r_dcnt + CNT_ONE;
            end
         end else begin
            // Any sample agreeing with the accepted level restarts the count.
            r_dcnt <= '0;
         end
      end
   end

   // Control FSM with prescaler; all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_pcnt    <= '0;
         r_enable  <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_enable <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_pcnt <= '0;
               // A press wins over a simultaneous step request.
               if (r_btn_evt) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end else if (bus.single_step) begin
                  r_state <= ST_STEP;
               end
            end
            ST_RUN: begin
               if (r_btn_evt) begin
                  r_state   <= ST_IDLE;
                  r_running <= 1'b0;
                  r_pcnt    <= '0;
               end else if (r_pcnt == PS_LAST) begin
                  // With PRESCALE=1 this fires every cycle.
                  r_pcnt   <= '0;
                  r_enable <= 1'b1;
               end else begin
                  r_pcnt <= r_pcnt + CNT_ONE;
               end
            end
            ST_STEP: begin
               r_enable <= 1'b1;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
               r_pcnt    <= '0;
            end
         endcase
      end
   end

   assign bus.enable  = r_enable;
   assign bus.running = r_running;
   assign bus.btn_evt = r_btn_evt;

endmodule

// File: tb/tb_counter_enable_ctrl.sv
// Bench for counter_enable_ctrl: two instances (DEBOUNCE=4/PRESCALE=10 and
// DEBOUNCE=1/PRESCALE=1) share one random/directed stimulus stream and are
// compared every cycle against a window/arithmetic reference model.
module tb_counter_enable_ctrl;

   localparam int D0 = 4;
   localparam int P0 = 10;
   localparam int D1 = 1;
   localparam int P1 = 1;
   localparam int MD_IDLE = 0;
   localparam int MD_RUN  = 1;
   localparam int MD_STEP = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   counter_enable_ctrl_if bus0 ();
   counter_enable_ctrl_if bus1 ();

   counter_enable_ctrl #(.DEBOUNCE(D0), .PRESCALE(P0), .CNT_W(8)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.slave)
   );

   counter_enable_ctrl #(.DEBOUNCE(D1), .PRESCALE(P1), .CNT_W(8)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   int total  = 0;
   int passed = 0;

   int dbv[2] = '{D0, D1};
   int psv[2] = '{P0, P1};

   // Reference model state.
   bit bq[$];          // raw button values sampled at recent edges
   bit sq[$];          // synchronised values seen by the debouncer at recent edges
   bit m_db[2];        // accepted level
   bit m_rise[2];      // accepted level rose at the latest edge
   bit m_evt[2];       // expected btn_evt
   bit m_en[2];        // expected enable
   bit m_run[2];       // expected running
   int m_mode[2];
   int m_rcnt[2];      // edges spent in RUN since entry

   function automatic void chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endfunction

   function void model_reset();
      bq.delete();
      sq.delete();
      for (int i = 0; i < 2; i++) begin
         m_db[i] = 1'b0; m_rise[i] = 1'b0; m_evt[i] = 1'b0;
         m_en[i] = 1'b0; m_run[i] = 1'b0;
         m_mode[i] = MD_IDLE; m_rcnt[i] = 0;
      end
   endfunction

   // Advance the model by one rising edge with the given pre-edge inputs.
   function void model_edge(input bit btn, input bit ss);
      bit s2;
      bit flip;
      // The debouncer sees the button value from two edges ago.
      s2 = (bq.size() >= 2) ? bq[bq.size()-2] : 1'b0;
      bq.push_back(btn);
      if (bq.size() > 4) void'(bq.pop_front());
      sq.push_back(s2);
      if (sq.size() > 16) void'(sq.pop_front());
      for (int i = 0; i < 2; i++) begin
         m_en[i] = 1'b0;
         case (m_mode[i])
            MD_IDLE: begin
               if (m_evt[i]) begin
                  m_mode[i] = MD_RUN;
                  m_rcnt[i] = 0;
               end else if (ss) begin
                  m_mode[i] = MD_STEP;
               end
            end
            MD_RUN: begin
               if (m_evt[i]) m_mode[i] = MD_IDLE;
               else begin
                  m_rcnt[i] = m_rcnt[i] + 1;
                  m_en[i] = (m_rcnt[i] % psv[i] == 0);
               end
            end
            default: begin
               m_en[i] = 1'b1;
               m_mode[i] = MD_IDLE;
            end
         endcase
         m_run[i] = (m_mode[i] == MD_RUN);
         m_evt[i] = m_rise[i];
         // Level accepted when the last DEBOUNCE samples all disagree with it.
         flip = (sq.size() >= dbv[i]);
         for (int k = 0; k < dbv[i] && flip; k++)
            if (sq[sq.size()-1-k] == m_db[i]) flip = 1'b0;
         m_rise[i] = flip && !m_db[i];
         if (flip) m_db[i] = !m_db[i];
      end
   endfunction

   task automatic compare_all();
      chk("enable0",  int'(bus0.enable),  int'(m_en[0]));
      chk("running0", int'(bus0.running), int'(m_run[0]));
      chk("btn_evt0", int'(bus0.btn_evt), int'(m_evt[0]));
      chk("enable1",  int'(bus1.enable),  int'(m_en[1]));
      chk("running1", int'(bus1.running), int'(m_run[1]));
      chk("btn_evt1", int'(bus1.btn_evt), int'(m_evt[1]));
   endtask

   task automatic drive(input bit btn, input bit ss);
      bus0.btn_in = btn; bus1.btn_in = btn;
      bus0.single_step = ss; bus1.single_step = ss;
   endtask

   task automatic tick(input bit btn, input bit ss);
      drive(btn, ss);
      model_edge(btn, ss);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      int  evt_t, run_t, n_evt, n_en, first_en, step_t, seen_run;
      bit  b, ss_nxt;
      int  hold;

      // Reset state.
      model_reset();
      drive(1'b0, 1'b0);
      reset = 1'b0;
      #2;
      compare_all();
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Press latency: btn high before edge 0.
      evt_t = -1; run_t = -1; n_evt = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b0);
         if (bus0.btn_evt) begin n_evt++; if (evt_t < 0) evt_t = k; end
         if (bus0.running && run_t < 0) run_t = k;
      end
      chk("press_evt_edge", evt_t, 6);
      chk("press_run_edge", run_t, 7);
      chk("press_evt_count", n_evt, 1);

      // Prescale: RUN entered at edge 7, strobes after 17, 27, 37.
      n_en = 0; first_en = -1;
      for (int k = 8; k < 38; k++) begin
         tick(1'b1, 1'b0);
         if (bus0.enable) begin n_en++; if (first_en < 0) first_en = k; end
      end
      chk("prescale_count", n_en, 3);
      chk("prescale_first", first_en, 17);

      // Release produces no event; second press stops.
      n_evt = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 1'b0);
         if (bus0.btn_evt) n_evt++;
      end
      chk("release_evt_count", n_evt, 0);
      chk("release_still_run", int'(bus0.running), 1);
      for (int k = 0; k < 20 && bus0.running; k++) tick(1'b1, 1'b0);
      chk("stop_running", int'(bus0.running), 0);
      n_en = 0;
      for (int k = 0; k < 20; k++) begin
         tick(1'b1, 1'b0);
         if (bus0.enable) n_en++;
      end
      chk("stop_no_enable", n_en, 0);
      for (int k = 0; k < 10; k++) tick(1'b0, 1'b0);

      // Single step: one enable, two edges after the request.
      n_en = 0; step_t = -1;
      for (int k = 0; k < 6; k++) begin
         tick(1'b0, k == 0);
         if (bus0.enable) begin n_en++; if (step_t < 0) step_t = k; end
      end
      chk("step_edge", step_t, 1);
      chk("step_count", n_en, 1);
      chk("step_running", int'(bus0.running), 0);

      // Glitch shorter than DEBOUNCE is rejected.
      n_evt = 0; seen_run = 0;
      for (int k = 0; k < 13; k++) begin
         tick(k < 3, 1'b0);
         if (bus0.btn_evt) n_evt++;
         if (bus0.running) seen_run++;
      end
      chk("glitch_evt", n_evt, 0);
      chk("glitch_run", seen_run, 0);

      // Collision: step request in the same cycle as btn_evt.
      ss_nxt = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, ss_nxt);
         ss_nxt = bus0.btn_evt;
      end
      chk("collide_running", int'(bus0.running), 1);
      n_en = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b0);
         if (bus0.enable) n_en++;
      end
      chk("collide_no_step", n_en, 0);

      // Random stimulus against the model.
      b = 1'b0; hold = 0;
      for (int k = 0; k < 1500; k++) begin
         if (hold == 0) begin
            b = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 9));
         end
         hold--;
         tick(b, $urandom_range(0, 7) == 0);
      end

      // Reset mid-RUN with a strobe due at the next edge.
      for (int k = 0; k < 10; k++) tick(1'b0, 1'b0);
      for (int a = 0; a < 3 && !bus0.running; a++) begin
         for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);
         for (int k = 0; k < 8; k++) tick(1'b0, 1'b0);
      end
      chk("pre_reset_running", int'(bus0.running), 1);
      for (int k = 0; k < 12 && !bus0.enable; k++) tick(1'b0, 1'b0);
      chk("pre_reset_strobe", int'(bus0.enable), 1);
      for (int k = 0; k < 9; k++) tick(1'b0, 1'b0);
      chk("pending_strobe", m_rcnt[0] % P0, P0 - 1);
      reset = 1'b0;
      #1;
      chk("mid_reset_enable",  int'(bus0.enable),  0);
      chk("mid_reset_running", int'(bus0.running), 0);
      chk("mid_reset_evt",     int'(bus0.btn_evt), 0);
      model_reset();
      compare_all();
      @(posedge clk); #1;
      @(posedge clk); #1;
      compare_all();
      reset = 1'b1;
      n_en = 0;
      for (int k = 0; k < 12; k++) begin
         tick(1'b0, 1'b0);
         if (bus0.enable) n_en++;
      end
      chk("post_reset_running", int'(bus0.running), 0);
      chk("post_reset_enable", n_en, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
